// File: rtl/dm_ctrl_dump_if.sv
// Core-side RAM access plus the host-link dump stream of dm_ctrl_dump.
// tx: a word transfers on a rising edge where tx_valid & tx_ready; tx_data holds while tx_valid & !tx_ready.
interface dm_ctrl_dump_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12,
    parameter int BUS_W  = 17
);
    logic [ADDR_W-1:0] ar_in;
    logic [BUS_W-1:0]  bus_in;
    logic              dm_en;
    logic              end_process;
    logic [DATA_W-1:0] dm_out;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              busy;
    logic              dump_done;

    modport master (
        output ar_in, bus_in, dm_en, end_process, tx_ready,
        input  dm_out, tx_valid, tx_data, busy, dump_done
    );

    modport slave (
        input  ar_in, bus_in, dm_en, end_process, tx_ready,
        output dm_out, tx_valid, tx_data, busy, dump_done
    );
endinterface

// File: rtl/dm_ctrl_dump.sv
// Data RAM serving core reads/writes; after end_process rises it streams
// DUMP_LEN words from DUMP_BASE over the tx valid/ready link, then reports done.
module dm_ctrl_dump #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 12,
    parameter int BUS_W     = 17,
    parameter int DUMP_BASE = 0,
    parameter int DUMP_LEN  = 16
) (
    input  logic           clk,
    input  logic           rst,
    dm_ctrl_dump_if.slave  bus,
    output logic [1:0]     dbg_state
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_IDX = (DUMP_LEN == 0) ? '0 : CNT_W'(DUMP_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(DUMP_BASE);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DUMP_RD = 2'd1,
        DUMP_TX = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ep_q;

    assign dbg_state = state;

    generate
        if (BUS_W > DATA_W) begin : g_drop
            logic unused_bus_hi;
            assign unused_bus_hi = ^bus.bus_in[BUS_W-1:DATA_W];
        end
    endgenerate

    // Core writes only land while running; the dump and DONE ignore dm_en.
    always_ff @(posedge clk) begin
        if (bus.dm_en && state == RUN)
            mem[bus.ar_in] <= bus.bus_in[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            bus.dm_out     <= '0;
            bus.tx_valid   <= 1'b0;
            bus.tx_data    <= '0;
            bus.busy       <= 1'b0;
            bus.dump_done  <= 1'b0;
            ptr            <= BASE;
            cnt            <= '0;
            ep_q           <= 1'b0;
        end else begin
            ep_q <= bus.end_process;
            case (state)
                RUN: begin
                    // Read-first: the nonblocking RAM write is not yet visible here.
                    bus.dm_out <= mem[bus.ar_in];
                    if (bus.end_process && !ep_q) begin
                        if (DUMP_LEN == 0) begin
                            state         <= DONE;
                            bus.dump_done <= 1'b1;
                        end else begin
                            state    <= DUMP_RD;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                DUMP_RD: begin
                    bus.tx_data  <= mem[ptr];
                    bus.tx_valid <= 1'b1;
                    state        <= DUMP_TX;
                end
                DUMP_TX: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        if (cnt == LAST_IDX) begin
                            state         <= DONE;
                            bus.busy      <= 1'b0;
                            bus.dump_done <= 1'b1;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            cnt   <= cnt + 1'b1;
                            state <= DUMP_RD;
                        end
                    end
                end
                DONE: begin
                    bus.dm_out <= mem[bus.ar_in];
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_ctrl_dump.sv
// Directed bench: main instance (base 0, len 4), a 4-bit wrap instance and a zero-length instance.
module tb_dm_ctrl_dump;
    localparam logic [1:0] S_RUN = 2'd0, S_RD = 2'd1, S_TX = 2'd2, S_DONE = 2'd3;

    logic clk, rst0, rst1, rst2;
    logic [1:0] st0, st1, st2;
    int n_cmp = 0;
    int n_bad = 0;

    dm_ctrl_dump_if #(.ADDR_W(12), .DATA_W(12), .BUS_W(17)) b0 ();
    dm_ctrl_dump_if #(.ADDR_W(4),  .DATA_W(12), .BUS_W(17)) b1 ();
    dm_ctrl_dump_if #(.ADDR_W(12), .DATA_W(12), .BUS_W(17)) b2 ();

    dm_ctrl_dump #(.ADDR_W(12), .DATA_W(12), .BUS_W(17), .DUMP_BASE(0), .DUMP_LEN(4))
        u0 (.clk(clk), .rst(rst0), .bus(b0.slave), .dbg_state(st0));
    dm_ctrl_dump #(.ADDR_W(4), .DATA_W(12), .BUS_W(17), .DUMP_BASE(14), .DUMP_LEN(4))
        u1 (.clk(clk), .rst(rst1), .bus(b1.slave), .dbg_state(st1));
    dm_ctrl_dump #(.ADDR_W(12), .DATA_W(12), .BUS_W(17), .DUMP_BASE(0), .DUMP_LEN(0))
        u2 (.clk(clk), .rst(rst2), .bus(b2.slave), .dbg_state(st2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [11:0] a, input logic [16:0] d);
        b0.dm_en = 1'b1; b0.ar_in = a; b0.bus_in = d;
        step();
        b0.dm_en = 1'b0;
    endtask

    task automatic wr1(input logic [3:0] a, input logic [16:0] d);
        b1.dm_en = 1'b1; b1.ar_in = a; b1.bus_in = d;
        step();
        b1.dm_en = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        b0.ar_in = '0; b0.bus_in = '0; b0.dm_en = 1'b0; b0.end_process = 1'b0; b0.tx_ready = 1'b0;
        b1.ar_in = '0; b1.bus_in = '0; b1.dm_en = 1'b0; b1.end_process = 1'b0; b1.tx_ready = 1'b0;
        b2.ar_in = '0; b2.bus_in = '0; b2.dm_en = 1'b0; b2.end_process = 1'b0; b2.tx_ready = 1'b0;
        #3;
        n_cmp++; if ({b0.dm_out, b0.tx_data} !== 24'h0) begin n_bad++;
            $display("FAIL reset_data: dm_out=%h tx_data=%h required 0", b0.dm_out, b0.tx_data); end
        n_cmp++; if ({b0.tx_valid, b0.busy, b0.dump_done} !== 3'b000) begin n_bad++;
            $display("FAIL reset_flags: valid/busy/done=%b required 000", {b0.tx_valid, b0.busy, b0.dump_done}); end
        n_cmp++; if (st0 !== S_RUN) begin n_bad++;
            $display("FAIL reset_state: got %0d required %0d", st0, S_RUN); end
        step();
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        step();
        n_cmp++; if ({b1.dump_done, b2.dump_done, b2.tx_valid} !== 3'b000) begin n_bad++;
            $display("FAIL reset_others: got %b required 000", {b1.dump_done, b2.dump_done, b2.tx_valid}); end
    endtask

    task automatic test_write_read();
        wr0(12'h005, 17'h1_0ABC);
        b0.ar_in = 12'h005;
        step();
        n_cmp++; if (b0.dm_out !== 12'hABC) begin n_bad++;
            $display("FAIL write_read: dm_out=%h required abc", b0.dm_out); end
    endtask

    task automatic test_collision();
        wr0(12'h010, 17'h0_0111);
        b0.dm_en = 1'b1; b0.ar_in = 12'h010; b0.bus_in = 17'h0_0222;
        step();
        b0.dm_en = 1'b0;
        n_cmp++; if (b0.dm_out !== 12'h111) begin n_bad++;
            $display("FAIL collision_old: dm_out=%h required 111", b0.dm_out); end
        step();
        n_cmp++; if (b0.dm_out !== 12'h222) begin n_bad++;
            $display("FAIL collision_new: dm_out=%h required 222", b0.dm_out); end
    endtask

    task automatic test_full_dump();
        for (int i = 0; i < 4; i++) wr0(12'(i), 17'(i + 1));
        b0.ar_in = 12'h002; b0.tx_ready = 1'b1; b0.end_process = 1'b1;
        step();
        n_cmp++; if ({b0.busy, b0.tx_valid, b0.dm_out} !== {2'b10, 12'h003}) begin n_bad++;
            $display("FAIL dump_start: busy=%b valid=%b dm_out=%h required 1 0 003", b0.busy, b0.tx_valid, b0.dm_out); end
        b0.ar_in = 12'h000;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if ({b0.tx_valid, b0.tx_data} !== {1'b1, 12'(i + 1)}) begin n_bad++;
                $display("FAIL dump_word%0d: valid=%b data=%h required 1 %h", i, b0.tx_valid, b0.tx_data, 12'(i + 1)); end
            step();
        end
        n_cmp++; if ({b0.dump_done, b0.busy, b0.tx_valid} !== 3'b100) begin n_bad++;
            $display("FAIL dump_done: done/busy/valid=%b required 100", {b0.dump_done, b0.busy, b0.tx_valid}); end
        n_cmp++; if (st0 !== S_DONE) begin n_bad++;
            $display("FAIL dump_state: got %0d required %0d", st0, S_DONE); end
        n_cmp++; if (b0.dm_out !== 12'h003) begin n_bad++;
            $display("FAIL dump_dm_hold: dm_out=%h required 003", b0.dm_out); end
        b0.dm_en = 1'b1; b0.bus_in = 17'h0_00FF;
        step();
        b0.dm_en = 1'b0;
        step();
        n_cmp++; if (b0.dm_out !== 12'h001) begin n_bad++;
            $display("FAIL done_write_ignored: dm_out=%h required 001", b0.dm_out); end
        for (int k = 0; k < 8; k++) begin
            step();
            n_cmp++; if ({b0.tx_valid, b0.dump_done, b0.busy} !== 3'b010) begin n_bad++;
                $display("FAIL no_retrigger: valid/done/busy=%b required 010", {b0.tx_valid, b0.dump_done, b0.busy}); end
        end
    endtask

    task automatic test_backpressure();
        rst0 = 1'b1; b0.end_process = 1'b0; b0.tx_ready = 1'b1;
        step();
        rst0 = 1'b0;
        b0.end_process = 1'b1;
        step();
        step();
        n_cmp++; if ({b0.tx_valid, b0.tx_data} !== {1'b1, 12'h001}) begin n_bad++;
            $display("FAIL bp_word0: valid=%b data=%h required 1 001", b0.tx_valid, b0.tx_data); end
        step();
        step();
        n_cmp++; if ({b0.tx_valid, b0.tx_data} !== {1'b1, 12'h002}) begin n_bad++;
            $display("FAIL bp_word1: valid=%b data=%h required 1 002", b0.tx_valid, b0.tx_data); end
        b0.tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++; if ({b0.tx_valid, b0.tx_data} !== {1'b1, 12'h002}) begin n_bad++;
                $display("FAIL bp_hold%0d: valid=%b data=%h required 1 002", k, b0.tx_valid, b0.tx_data); end
        end
        b0.tx_ready = 1'b1;
        step();
        n_cmp++; if (b0.tx_valid !== 1'b0) begin n_bad++;
            $display("FAIL bp_release: valid=%b required 0", b0.tx_valid); end
        step();
        n_cmp++; if ({b0.tx_valid, b0.tx_data} !== {1'b1, 12'h003}) begin n_bad++;
            $display("FAIL bp_word2: valid=%b data=%h required 1 003", b0.tx_valid, b0.tx_data); end
        step();
        step();
        n_cmp++; if ({b0.tx_valid, b0.tx_data} !== {1'b1, 12'h004}) begin n_bad++;
            $display("FAIL bp_word3: valid=%b data=%h required 1 004", b0.tx_valid, b0.tx_data); end
        step();
        n_cmp++; if ({b0.dump_done, b0.tx_valid} !== 2'b10) begin n_bad++;
            $display("FAIL bp_done: done/valid=%b required 10", {b0.dump_done, b0.tx_valid}); end
    endtask

    task automatic test_reset_mid_dump();
        rst0 = 1'b1; b0.end_process = 1'b0; b0.tx_ready = 1'b0;
        step();
        rst0 = 1'b0;
        b0.end_process = 1'b1;
        step();
        step();
        n_cmp++; if ({b0.tx_valid, st0} !== {1'b1, S_TX}) begin n_bad++;
            $display("FAIL mid_pre: valid=%b state=%0d required 1 %0d", b0.tx_valid, st0, S_TX); end
        #2 rst0 = 1'b1;
        #1;
        n_cmp++; if ({b0.tx_valid, b0.busy, st0, b0.tx_data} !== {2'b00, S_RUN, 12'h000}) begin n_bad++;
            $display("FAIL mid_abort: valid=%b busy=%b state=%0d data=%h required 0 0 0 000", b0.tx_valid, b0.busy, st0, b0.tx_data); end
        b0.tx_ready = 1'b1; b0.end_process = 1'b0;
        step();
        rst0 = 1'b0;
        b0.ar_in = 12'h005;
        step();
        n_cmp++; if ({b0.tx_valid, b0.dm_out} !== {1'b0, 12'hABC}) begin n_bad++;
            $display("FAIL ram_kept_005: valid=%b dm_out=%h required 0 abc", b0.tx_valid, b0.dm_out); end
        b0.ar_in = 12'h010;
        step();
        n_cmp++; if (b0.dm_out !== 12'h222) begin n_bad++;
            $display("FAIL ram_kept_010: dm_out=%h required 222", b0.dm_out); end
    endtask

    task automatic test_wrap();
        logic [11:0] exp_w [4];
        exp_w = '{12'h0E1, 12'h0F2, 12'h003, 12'h014};
        wr1(4'd14, 17'h0_00E1);
        wr1(4'd15, 17'h0_00F2);
        wr1(4'd0,  17'h1_0003);
        wr1(4'd1,  17'h0_0014);
        wr1(4'd2,  17'h0_0555);
        b1.tx_ready = 1'b1; b1.end_process = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if ({b1.tx_valid, b1.tx_data} !== {1'b1, exp_w[i]}) begin n_bad++;
                $display("FAIL wrap_word%0d: valid=%b data=%h required 1 %h", i, b1.tx_valid, b1.tx_data, exp_w[i]); end
            step();
        end
        step();
        n_cmp++; if ({b1.dump_done, b1.tx_valid, b1.busy} !== 3'b100) begin n_bad++;
            $display("FAIL wrap_done: done/valid/busy=%b required 100", {b1.dump_done, b1.tx_valid, b1.busy}); end
    endtask

    task automatic test_len_zero();
        b2.tx_ready = 1'b1; b2.end_process = 1'b1;
        step();
        n_cmp++; if ({b2.dump_done, b2.tx_valid, b2.busy, st2} !== {3'b100, S_DONE}) begin n_bad++;
            $display("FAIL len0_done: done/valid/busy=%b state=%0d required 100 %0d", {b2.dump_done, b2.tx_valid, b2.busy}, st2, S_DONE); end
        step();
        n_cmp++; if ({b2.dump_done, b2.tx_valid} !== 2'b10) begin n_bad++;
            $display("FAIL len0_hold: done/valid=%b required 10", {b2.dump_done, b2.tx_valid}); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_full_dump();
        test_backpressure();
        test_reset_mid_dump();
        test_wrap();
        test_len_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
